// File: rtl/burst_seq_pkg.sv
// burst_seq_pkg: shared state encoding for the burst address sequencer.
package burst_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, GAP} burst_state_t;
endpackage

// File: rtl/burst_addr_sequencer.sv
// burst_addr_sequencer: issues one incrementing address per beat of a burst and
// inserts a one-cycle bubble before non-first beats that land on a quadrant boundary.
module burst_addr_sequencer
    import burst_seq_pkg::*;
#(
    parameter int N     = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_start,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_split_en,
    input  logic             abort,
    output logic [N-1:0]     address,
    output logic             addr_valid,
    input  logic             addr_ready,
    input  logic             boundary_flag,
    output logic             seg_first,
    output logic             last,
    output logic             busy,
    output logic             done
);
    burst_state_t     state_q, state_d;
    logic [N-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0] beats_q, beats_d;
    logic             split_q, split_d, first_q, first_d, done_q, done_d;
    logic             bubble, hs;

    always_comb begin
        bubble     = state_q == RUN && split_q && boundary_flag && !first_q;
        addr_valid = (state_q == RUN && !bubble) || state_q == GAP;
        seg_first  = addr_valid && (state_q == GAP || first_q);
        last       = state_q != IDLE && beats_q == '0;
        busy       = state_q != IDLE;
        done       = done_q;
        cmd_ready  = state_q == IDLE && !abort;
        address    = addr_q;
        hs         = addr_valid && addr_ready;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        split_d = split_q;
        first_d = first_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (cmd_valid && cmd_ready) begin
                state_d = RUN;
                addr_d  = cmd_start;
                beats_d = cmd_len;
                split_d = cmd_split_en;
                first_d = 1'b1;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else if (bubble) begin
            state_d = GAP;
        end else if (hs) begin
            if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
                addr_d  = addr_q + 1'b1;
                beats_d = beats_q - 1'b1;
                first_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            split_q <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            split_q <= split_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_burst_addr_sequencer.sv
// tb_burst_addr_sequencer: directed bursts against a scoreboard of expected beats,
// with a local quadrant-boundary decoder standing in for the downstream block.
module tb_burst_addr_sequencer;
    logic        clk = 1'b0, rstN = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_split_en, abort;
    logic [15:0] cmd_start, address;
    logic [7:0]  cmd_len;
    logic        addr_valid, addr_ready, boundary_flag, seg_first, last, busy, done;

    typedef struct {
        logic [15:0] a;
        logic        s, l, b;
    } beat_t;

    beat_t q[$];
    beat_t e;
    int    checks = 0, errors = 0, done_cnt = 0;

    burst_addr_sequencer #(.N(16), .LEN_W(8)) dut (
        .clk(clk), .rstN(rstN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_split_en(cmd_split_en),
        .abort(abort), .address(address), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .boundary_flag(boundary_flag),
        .seg_first(seg_first), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign boundary_flag = address[13:0] == 14'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic        gap_seen = 1'b0, hold_v = 1'b0, done_exp = 1'b0;
    logic [15:0] hold_a;
    logic        hold_l, hold_s;

    always @(negedge clk) begin
        if (!rstN) begin
            gap_seen = 1'b0;
            hold_v   = 1'b0;
            done_exp = 1'b0;
        end else begin
            chk("done", done, done_exp);
            if (done) done_cnt++;
            if (hold_v) begin
                chk("hold_valid", addr_valid, 1);
                chk("hold_addr", address, hold_a);
                chk("hold_last", last, hold_l);
                chk("hold_seg", seg_first, hold_s);
            end
            if (!busy) gap_seen = 1'b0;
            else if (!addr_valid) gap_seen = 1'b1;
            if (addr_valid && addr_ready) begin
                if (q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("addr", address, e.a);
                    chk("seg_first", seg_first, e.s);
                    chk("last", last, e.l);
                    chk("bubble", gap_seen, e.b);
                end
                gap_seen = 1'b0;
            end
            hold_v   = addr_valid && !addr_ready && !abort;
            hold_a   = address;
            hold_l   = last;
            hold_s   = seg_first;
            done_exp = addr_valid && addr_ready && last && !abort;
        end
    end

    task automatic send(input logic [15:0] start, input logic [7:0] len, input logic split);
        for (int i = 0; i <= int'(len); i++) begin
            beat_t b;
            b.a = start + 16'(i);
            b.b = split && i != 0 && b.a[13:0] == 14'd0;
            b.s = i == 0 || b.b;
            b.l = i == int'(len);
            q.push_back(b);
        end
        cmd_start    = start;
        cmd_len      = len;
        cmd_split_en = split;
        cmd_valid    = 1'b1;
        #1 chk("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("busy_after_cmd", busy, 1);
    endtask

    task automatic finish_burst(input logic rnd);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rnd) addr_ready = 1'($urandom_range(0, 1));
            if (q.size() == 0 && !busy) break;
        end
        chk("drain_queue", q.size(), 0);
        chk("drain_idle", busy, 0);
        addr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        cmd_valid = 0; cmd_start = 0; cmd_len = 0; cmd_split_en = 0;
        abort = 0; addr_ready = 1;
        #12;
        chk("rst_valid", addr_valid, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_addr", address, 0);
        chk("rst_last_seg_done", {last, seg_first, done}, 0);
        @(posedge clk);
        #1 rstN = 1'b1;

        send(16'h3FFE, 8'd3, 1'b1);
        finish_burst(1'b0);
        chk("done_cnt_split", done_cnt, 1);

        send(16'h3FFE, 8'd3, 1'b0);
        finish_burst(1'b0);
        chk("done_cnt_nosplit", done_cnt, 2);

        send(16'hFFFE, 8'd2, 1'b1);
        finish_burst(1'b0);
        chk("done_cnt_wrap", done_cnt, 3);

        send(16'h8000, 8'd0, 1'b1);
        finish_burst(1'b0);
        chk("done_cnt_single", done_cnt, 4);

        send(16'h7FF8, 8'd15, 1'b1);
        finish_burst(1'b1);
        chk("done_cnt_stall", done_cnt, 5);

        send(16'h0100, 8'd7, 1'b0);
        for (int i = 0; i < 50 && q.size() > 6; i++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_pos", q.size(), 6);
        addr_ready = 1'b0;
        abort      = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        addr_ready = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", addr_valid, 0);
        q.delete();
        repeat (4) @(posedge clk);
        #1 chk("abort_no_done", done_cnt, 5);

        cmd_valid = 1'b1;
        abort     = 1'b1;
        cmd_start = 16'h1234;
        #1 chk("idle_abort_ready", cmd_ready, 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        send(16'h2000, 8'd1, 1'b1);
        finish_burst(1'b0);
        chk("done_cnt_after_abort", done_cnt, 6);

        send(16'h5000, 8'd0, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        finish_burst(1'b0);
        chk("final_abort_no_done", done_cnt, 6);

        send(16'h6000, 8'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", addr_valid, 0);
        chk("midrst_addr", address, 0);
        q.delete();
        @(posedge clk);
        #1 rstN = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("midrst_no_done", done_cnt, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
